console_uart_tx: RTL and testbench

//  Buffered console transmitter: the responder for the CPU's console-write register handshake.
//  The CPU writes bytes via reg_dat_we and waits while reg_dat_wait is high. Bytes are queued in a FIFO.
//  The FIFO drains onto ser_tx (PIN_1) as 8N1 frames, so the core stalls only when the FIFO is full.

---
 rtl/console_uart_tx_pkg.sv | 17 +
 rtl/console_tx_fifo.sv | 47 ++++
 rtl/console_uart_tx.sv | 108 ++++++++++
 tb/tb_console_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/console_uart_tx_pkg.sv
// rtl/console_uart_tx_pkg.sv - shared constants for the buffered console transmitter
// Divider default, TX state encodings and the bit-period clamp.
package console_uart_tx_pkg;

  localparam logic [31:0] UART_DIV_300_16M = 32'd53333;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Divider values 0 and 1 cannot make a countdown-from-div-1 bit; clamp to 2.
  function automatic logic [31:0] bit_period(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

endpackage

// File: rtl/console_tx_fifo.sv
// rtl/console_tx_fifo.sv - synchronous byte FIFO feeding the console transmitter
// Show-ahead read: data is the head entry whenever not empty.
module console_tx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Occupancy never exceeds 2**AW, so the top count bit alone means full.
  assign full     = level[AW];
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/console_uart_tx.sv
// rtl/console_uart_tx.sv - buffered 8N1 console transmitter with divider register
// CPU writes stall only while the FIFO is full; frames drain back-to-back.
module console_uart_tx
  import console_uart_tx_pkg::*;
#(
  parameter int          FIFO_AW     = 4,
  parameter logic [31:0] DEFAULT_DIV = UART_DIV_300_16M
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [3:0]         reg_div_we,
  input  logic [31:0]        reg_div_di,
  output logic [31:0]        reg_div_do,
  input  logic               reg_dat_we,
  input  logic [31:0]        reg_dat_di,
  output logic               reg_dat_wait,
  output logic               ser_tx,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   tx_level
);

  logic [31:0] div;
  logic [1:0]  state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic [31:0] bit_cnt;
  logic [31:0] div_lat;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        frame_go;
  logic        bit_end;
  logic        unused_hi;

  assign unused_hi    = ^reg_dat_di[31:8];
  assign reg_div_do   = div;
  assign reg_dat_wait = reg_dat_we && fifo_full;
  assign tx_busy      = !fifo_empty || (state != ST_IDLE);
  assign bit_end      = (bit_cnt == 32'd0);
  // A new frame starts from idle, or straight out of a finished stop bit.
  assign frame_go     = !fifo_empty &&
                        ((state == ST_IDLE) || (state == ST_STOP && bit_end));

  console_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (reg_dat_we && !fifo_full),
    .push_data (reg_dat_di[7:0]),
    .pop       (frame_go),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (tx_level)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div <= DEFAULT_DIV;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_div_we[i]) div[8*i +: 8] <= reg_div_di[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      ser_tx  <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
      bit_cnt <= '0;
      div_lat <= 32'd2;
    end else if (frame_go) begin
      // Divider is captured here so mid-frame register writes only affect later frames.
      shreg   <= fifo_data;
      div_lat <= bit_period(div);
      bit_cnt <= bit_period(div) - 32'd1;
      ser_tx  <= 1'b0;
      state   <= ST_START;
    end else if (state != ST_IDLE) begin
      if (!bit_end) begin
        bit_cnt <= bit_cnt - 32'd1;
      end else begin
        bit_cnt <= div_lat - 32'd1;
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            bit_idx <= 3'd0;
            ser_tx  <= shreg[0];
          end
          ST_DATA: begin
            if (bit_idx == 3'd7) begin
              state  <= ST_STOP;
              ser_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              ser_tx  <= shreg[1];
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_console_uart_tx.sv
// tb/tb_console_uart_tx.sv - self-checking bench for console_uart_tx
// Frames on ser_tx are decoded independently and matched against the bytes the bench wrote.
`timescale 1ns/1ps
module tb_console_uart_tx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  reg_div_we = '0;
  logic [31:0] reg_div_di = '0;
  logic [31:0] reg_div_do;
  logic        reg_dat_we = 1'b0;
  logic [31:0] reg_dat_di = '0;
  logic        reg_dat_wait;
  logic        ser_tx;
  logic        tx_busy;
  logic [4:0]  tx_level;

  console_uart_tx dut (
    .clk          (clk),
    .resetn       (resetn),
    .reg_div_we   (reg_div_we),
    .reg_div_di   (reg_div_di),
    .reg_div_do   (reg_div_do),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_wait (reg_dat_wait),
    .ser_tx       (ser_tx),
    .tx_busy      (tx_busy),
    .tx_level     (tx_level)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          peak = 0;
  bit          mon_en = 1'b0;
  logic [31:0] cur_div = 32'd53333;
  logic [7:0]  exp_q[$];
  int          starts[$];

  typedef struct {
    logic [3:0]  we;
    logic [31:0] di;
    logic [31:0] exp_do;
  } div_vec_t;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (int'(tx_level) > peak) peak <= int'(tx_level);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff(input logic [31:0] d);
    return (d < 32'd2) ? 2 : int'(d);
  endfunction

  // Frame decoder: samples every clock of a 10-bit frame at the divider in force at its start.
  initial begin
    int d, st;
    logic [9:0] v;
    bit bad, abort, prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!resetn) prev = 1'b1;
      else if (mon_en && prev && ser_tx === 1'b0) begin
        d = eff(cur_div); st = cyc; v = '0; v[0] = ser_tx; bad = 0; abort = 0;
        for (int c = 1; c < 10*d; c++) begin
          @(negedge clk);
          if (!resetn) begin abort = 1; break; end
          if (c % d == 0) v[c/d] = ser_tx;
          else if (ser_tx !== v[c/d]) bad = 1;
        end
        if (!abort) begin
          starts.push_back(st);
          check("frame_format", 32'({bad, v[0], v[9]}), 32'b001);
          if (exp_q.size() == 0) check("frame_unexpected", 32'(v[8:1]), 32'hxx);
          else check("frame_byte", 32'(v[8:1]), 32'(exp_q.pop_front()));
        end
        prev = 1'b1;
      end else prev = ser_tx;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with we still high.
  task automatic write_byte(input logic [7:0] b, output int waited);
    reg_dat_we = 1'b1;
    reg_dat_di = ($urandom & 32'hFFFF_FF00) | 32'(b);
    waited = 0;
    #1;
    while (reg_dat_wait && waited < 3000) begin
      @(negedge clk); #1; waited++;
    end
    if (reg_dat_wait) begin
      errors++;
      $display("FAIL write_timeout: wait still 1 after %0d cycles", waited);
    end
    exp_q.push_back(b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_div(input logic [3:0] we, input logic [31:0] di);
    reg_div_we = we; reg_div_di = di;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) if (we[i]) cur_div[8*i +: 8] = di[8*i +: 8];
    reg_div_we = '0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    reg_dat_we = 1'b0;
    while (tx_busy && n < 20000) begin @(negedge clk); n++; end
    if (tx_busy) begin
      errors++;
      $display("FAIL drain_timeout: tx_busy still 1 after %0d cycles", n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_gap(input string name, input int exp_gap);
    int sz;
    sz = starts.size();
    if (sz < 2) check(name, 32'(sz), 32'd2);
    else check(name, 32'(starts[sz-1] - starts[sz-2]), 32'(exp_gap));
  endtask

  div_vec_t dv[6];
  logic [31:0] divs[5];

  initial begin
    int w, n, wsum;
    dv[0] = '{4'hF, 32'h1234_5678, 32'h1234_5678};
    dv[1] = '{4'h1, 32'h0000_00AA, 32'h1234_56AA};
    dv[2] = '{4'h6, 32'h00BB_CC00, 32'h12BB_CCAA};
    dv[3] = '{4'h0, 32'hFFFF_FFFF, 32'h12BB_CCAA};
    dv[4] = '{4'h8, 32'hEE00_0000, 32'hEEBB_CCAA};
    dv[5] = '{4'hC, 32'h0000_0000, 32'h0000_CCAA};
    divs  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd5};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ser_tx", 32'(ser_tx), 32'd1);
    check("rst_div", reg_div_do, 32'd53333);
    check("rst_level", 32'(tx_level), 32'd0);
    check("rst_wait", 32'(reg_dat_wait), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Byte-lane divider writes
    for (int i = 0; i < 6; i++) begin
      write_div(dv[i].we, dv[i].di);
      check($sformatf("div_vec%0d", i), reg_div_do, dv[i].exp_do);
    end
    write_div(4'hF, 32'd4);
    check("div_4", reg_div_do, 32'd4);
    mon_en = 1'b1;

    // Single 0x55 frame: latency and busy length
    write_byte(8'h55, w);
    reg_dat_we = 1'b0;
    check("latency_pre", 32'(ser_tx), 32'd1);
    @(negedge clk);
    check("latency_start", 32'(ser_tx), 32'd0);
    n = 0;
    while (tx_busy && n < 100) begin @(negedge clk); n++; end
    check("busy_len", 32'(n), 32'd40);
    drain();

    // Back-to-back frames
    write_byte(8'h41, w);
    write_byte(8'h42, w);
    drain();
    check_gap("b2b_gap", 40);

    // Fill: one frame in flight, then 17 writes
    peak = 0; wsum = 0;
    write_byte(8'h10, w);
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(8'hA0 + i), w);
      if (i < 16) wsum += w;
    end
    reg_dat_we = 1'b0;
    check("fill_nowait", 32'(wsum), 32'd0);
    check("fill_wait17", 32'(w), 32'd25);
    check("fill_peak", 32'(peak), 32'd16);
    drain();

    // Divider change mid-frame
    write_byte(8'h3C, w);
    write_byte(8'hC3, w);
    reg_dat_we = 1'b0;
    repeat (14) @(negedge clk);
    write_div(4'h1, 32'd8);
    drain();
    check_gap("middiv_gap", 40);
    write_div(4'hF, 32'd4);

    // Random traffic with divider clamp values
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        drain();
        write_div(4'hF, divs[$urandom_range(0, 4)]);
      end
      write_byte(8'($urandom), w);
      n = $urandom_range(0, 3);
      if (n != 0) begin
        reg_dat_we = 1'b0;
        repeat (n) @(negedge clk);
      end
    end
    drain();
    check("rand_all_sent", 32'(exp_q.size()), 32'd0);
    write_div(4'hF, 32'd4);

    // Reset in the middle of a data bit
    write_byte(8'hA5, w);
    reg_dat_we = 1'b0;
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_ser_tx", 32'(ser_tx), 32'd1);
    check("midrst_level", 32'(tx_level), 32'd0);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_div", reg_div_do, 32'd53333);
    resetn = 1'b1;
    exp_q.delete();
    cur_div = 32'd53333;
    @(negedge clk);
    write_byte(8'hFF, w);
    reg_dat_we = 1'b0;
    exp_q.delete();
    check("post_rst_idle", 32'(ser_tx), 32'd1);
    @(negedge clk);
    check("post_rst_start", 32'(ser_tx), 32'd0);
    n = 0;
    while (!ser_tx && n < 60000) begin @(negedge clk); n++; end
    check("post_rst_start_width", 32'(n), 32'd53333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
